// File: rtl/mpy_arbiter_if.sv
// Bundle between mpy_arbiter and its requesters, the shared multiplier and the result consumer.
// Signal names carry the arbiter's direction (i_ = into the arbiter, o_ = out of it).
interface mpy_arbiter_if #(
  parameter int NA   = 12,
  parameter int NB   = 12,
  parameter int NREQ = 4
);
  localparam int IDXW = $clog2(NREQ);

  logic [NREQ-1:0]    i_req_valid;
  logic [NREQ-1:0]    o_req_ready;
  logic [NREQ*NA-1:0] i_req_a;
  logic [NREQ*NB-1:0] i_req_b;
  logic               o_mpy_ce;
  logic [NA-1:0]      o_mpy_a;
  logic [NB-1:0]      o_mpy_b;
  logic               o_mpy_aux;
  logic [NA+NB-1:0]   i_mpy_p;
  logic               o_res_valid;
  logic [IDXW-1:0]    o_res_idx;
  logic [NA+NB-1:0]   o_res_p;
  logic               i_res_ready;

  modport slave (
    input  i_req_valid, i_req_a, i_req_b, i_mpy_p, i_res_ready,
    output o_req_ready, o_mpy_ce, o_mpy_a, o_mpy_b, o_mpy_aux,
    output o_res_valid, o_res_idx, o_res_p
  );

  modport master (
    output i_req_valid, i_req_a, i_req_b, i_mpy_p, i_res_ready,
    input  o_req_ready, o_mpy_ce, o_mpy_a, o_mpy_b, o_mpy_aux,
    input  o_res_valid, o_res_idx, o_res_p
  );
endinterface

// File: rtl/mpy_arbiter.sv
// Shares one pipelined multiplier among NREQ requesters; tags track result ownership.
// Define MPY_ARBITER_FIXED_PRIO_EN for fixed priority (lowest index wins) instead of round-robin.
module mpy_arbiter #(
  parameter int NA   = 12,
  parameter int NB   = 12,
  parameter int NREQ = 4,
  parameter int LAT  = 3
) (
  input  logic          i_clk,
  input  logic          i_reset_n,
  mpy_arbiter_if.slave  bus
);
  localparam int IDXW = $clog2(NREQ);

  logic            w_mpy_ce;
  logic            w_grant;
  logic [IDXW-1:0] w_gnt_idx;

  logic            r_tag_v   [LAT];
  logic [IDXW-1:0] r_tag_idx [LAT];
  logic            r_res_valid;
  logic [IDXW-1:0] r_res_idx;
  logic [NA+NB-1:0] r_res_p;

  // A held result stalls the entire multiplier pipeline.
  assign w_mpy_ce = !r_res_valid || bus.i_res_ready;
  assign w_grant  = w_mpy_ce && (|bus.i_req_valid);

`ifdef MPY_ARBITER_FIXED_PRIO_EN
  // Lowest-index valid requester; scanning downward lets the lowest index overwrite last.
  always_comb begin
    w_gnt_idx = '0;
    for (int k = NREQ - 1; k >= 0; k--) begin
      w_gnt_idx = bus.i_req_valid[k] ? IDXW'(k) : w_gnt_idx;
    end
  end
`else
  logic [IDXW-1:0] r_ptr;
  logic [IDXW:0]   w_sum;
  logic [IDXW-1:0] w_cand;

  // Round-robin: first valid requester at offsets 1..NREQ after the last grant.
  always_comb begin
    w_gnt_idx = '0;
    w_sum     = '0;
    w_cand    = '0;
    for (int k = NREQ; k >= 1; k--) begin
      w_sum     = {1'b0, r_ptr} + (IDXW+1)'(k);
      w_cand    = (w_sum >= (IDXW+1)'(NREQ)) ? IDXW'(w_sum - (IDXW+1)'(NREQ)) : IDXW'(w_sum);
      w_gnt_idx = bus.i_req_valid[w_cand] ? w_cand : w_gnt_idx;
    end
  end
`endif

  // Grant-cycle handshake and operand steering toward the multiplier.
  always_comb begin
    bus.o_mpy_ce = w_mpy_ce;
    if (w_grant) begin
      bus.o_req_ready = NREQ'(1) << w_gnt_idx;
      bus.o_mpy_a     = bus.i_req_a[w_gnt_idx*NA +: NA];
      bus.o_mpy_b     = bus.i_req_b[w_gnt_idx*NB +: NB];
      bus.o_mpy_aux   = 1'b1;
    end else begin
      bus.o_req_ready = '0;
      bus.o_mpy_a     = '0;
      bus.o_mpy_b     = '0;
      bus.o_mpy_aux   = 1'b0;
    end
  end

  // Tag pipeline, result register and arbitration pointer all advance only on o_mpy_ce.
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      for (int i = 0; i < LAT; i++) begin
        r_tag_v[i]   <= 1'b0;
        r_tag_idx[i] <= '0;
      end
      r_res_valid <= 1'b0;
      r_res_idx   <= '0;
      r_res_p     <= '0;
`ifndef MPY_ARBITER_FIXED_PRIO_EN
      r_ptr       <= IDXW'(NREQ - 1);
`endif
    end else if (w_mpy_ce) begin
      r_tag_v[0]   <= w_grant;
      r_tag_idx[0] <= w_gnt_idx;
      for (int i = 1; i < LAT; i++) begin
        r_tag_v[i]   <= r_tag_v[i-1];
        r_tag_idx[i] <= r_tag_idx[i-1];
      end
      r_res_valid <= r_tag_v[LAT-1];
      if (r_tag_v[LAT-1]) begin
        r_res_idx <= r_tag_idx[LAT-1];
        r_res_p   <= bus.i_mpy_p;
      end else begin
        r_res_idx <= r_res_idx;
        r_res_p   <= r_res_p;
      end
`ifndef MPY_ARBITER_FIXED_PRIO_EN
      if (w_grant) begin
        r_ptr <= w_gnt_idx;
      end else begin
        r_ptr <= r_ptr;
      end
`endif
    end else begin
      r_res_valid <= r_res_valid;
    end
  end

  assign bus.o_res_valid = r_res_valid;
  assign bus.o_res_idx   = r_res_idx;
  assign bus.o_res_p     = r_res_p;
endmodule

// File: tb/tb_mpy_arbiter.sv
// Self-checking bench for mpy_arbiter: directed tables, corner sequences and a
// randomized run against a queue-based model of grant order and result delivery.
module tb_mpy_arbiter;
  localparam int NA   = 12;
  localparam int NB   = 12;
  localparam int NREQ = 4;
  localparam int LAT  = 3;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  mpy_arbiter_if #(.NA(NA), .NB(NB), .NREQ(NREQ)) bus();

  mpy_arbiter #(.NA(NA), .NB(NB), .NREQ(NREQ), .LAT(LAT)) dut (
    .i_clk     (clk),
    .i_reset_n (rst_n),
    .bus       (bus)
  );

  // Shared multiplier: LAT enabled stages, deliberately not reset.
  logic [23:0] mp [LAT] = '{default: 24'd0};
  always @(posedge clk) begin
    if (bus.o_mpy_ce) begin
      mp[0] <= {12'd0, bus.o_mpy_a} * {12'd0, bus.o_mpy_b};
      for (int i = 1; i < LAT; i++) mp[i] <= mp[i-1];
    end
  end
  assign bus.i_mpy_p = mp[LAT-1];

  int n_chk  = 0;
  int n_fail = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: results are queued in grant order and age one step per enabled cycle.
  typedef struct {
    int          idx;
    logic [23:0] p;
    int          age;
  } inf_t;

  inf_t        q[$];
  int          m_ptr = NREQ - 1;
  bit          m_res_valid = 1'b0;
  int          m_res_idx;
  logic [23:0] m_res_p;

  function automatic int pick(input logic [3:0] v, input int ptr);
`ifdef MPY_ARBITER_FIXED_PRIO_EN
    for (int i = 0; i < NREQ; i++) if (v[i]) return i;
`else
    for (int k = 1; k <= NREQ; k++) if (v[(ptr + k) % NREQ]) return (ptr + k) % NREQ;
`endif
    return -1;
  endfunction

  initial begin : model
    int          g;
    bit          exp_ce;
    logic [11:0] ea, eb;
    logic [3:0]  er;
    inf_t        it;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        q.delete();
        m_ptr       = NREQ - 1;
        m_res_valid = 1'b0;
      end else begin
        exp_ce = !m_res_valid || bus.i_res_ready;
        g      = exp_ce ? pick(bus.i_req_valid, m_ptr) : -1;
        ea     = (g >= 0) ? bus.i_req_a[g*NA +: NA] : 12'd0;
        eb     = (g >= 0) ? bus.i_req_b[g*NB +: NB] : 12'd0;
        er     = (g >= 0) ? 4'(1 << g) : 4'd0;
        check("m_ce",    64'(bus.o_mpy_ce),    64'(exp_ce));
        check("m_ready", 64'(bus.o_req_ready), 64'(er));
        check("m_aux",   64'(bus.o_mpy_aux),   64'(g >= 0));
        check("m_mpy_a", 64'(bus.o_mpy_a),     64'(ea));
        check("m_mpy_b", 64'(bus.o_mpy_b),     64'(eb));
        check("m_res_valid", 64'(bus.o_res_valid), 64'(m_res_valid));
        if (m_res_valid) begin
          check("m_res_idx", 64'(bus.o_res_idx), 64'(m_res_idx));
          check("m_res_p",   64'(bus.o_res_p),   64'(m_res_p));
        end
        if (exp_ce) begin
          if (q.size() > 0 && q[0].age == LAT) begin
            m_res_valid = 1'b1;
            m_res_idx   = q[0].idx;
            m_res_p     = q[0].p;
            void'(q.pop_front());
          end else begin
            m_res_valid = 1'b0;
          end
          foreach (q[i]) q[i].age++;
          if (g >= 0) begin
            it.idx = g;
            it.p   = {12'd0, ea} * {12'd0, eb};
            it.age = 1;
            q.push_back(it);
            m_ptr = g;
          end
        end
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input logic [3:0] v);
    bus.i_req_valid = v;
    for (int i = 0; i < NREQ; i++) begin
      bus.i_req_a[i*NA +: NA] = 12'($urandom);
      bus.i_req_b[i*NB +: NB] = 12'($urandom);
    end
  endtask

  task automatic pulse_reset();
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
  endtask

  task automatic wait_result(input string name, output int cyc);
    cyc = 1;
    while (!bus.o_res_valid && cyc < 10) begin
      step();
      cyc++;
    end
    if (!bus.o_res_valid) check({name, "_timeout"}, 64'(bus.o_res_valid), 64'd1);
  endtask

  typedef struct {
    logic [3:0] valid;
    logic [3:0] exp_rr;
    logic [3:0] exp_fp;
  } vec_t;

  vec_t tbl[10];

  initial begin : stim
    int          cyc;
    int          n_res;
    int          first_c, last_c;
    int          idxs[$];
    logic [23:0] held;
    logic [3:0]  exp;

    tbl[0] = '{4'b0000, 4'b0000, 4'b0000};
    tbl[1] = '{4'b1010, 4'b0010, 4'b0010};
    tbl[2] = '{4'b1010, 4'b1000, 4'b0010};
    tbl[3] = '{4'b1010, 4'b0010, 4'b0010};
    tbl[4] = '{4'b0001, 4'b0001, 4'b0001};
    tbl[5] = '{4'b0001, 4'b0001, 4'b0001};
    tbl[6] = '{4'b1111, 4'b0010, 4'b0001};
    tbl[7] = '{4'b1100, 4'b0100, 4'b0100};
    tbl[8] = '{4'b0100, 4'b0100, 4'b0100};
    tbl[9] = '{4'b0011, 4'b0001, 4'b0001};

    bus.i_req_valid = '0;
    bus.i_req_a     = '0;
    bus.i_req_b     = '0;
    bus.i_res_ready = 1'b1;
    #1;
    check("rst_res_valid", 64'(bus.o_res_valid), 64'd0);
    check("rst_res_idx",   64'(bus.o_res_idx),   64'd0);
    check("rst_res_p",     64'(bus.o_res_p),     64'd0);
    check("rst_ce",        64'(bus.o_mpy_ce),    64'd1);
    check("rst_ready",     64'(bus.o_req_ready), 64'd0);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;

    // Arbitration table starting from the post-reset pointer.
    for (int i = 0; i < 10; i++) begin
      set_req(tbl[i].valid);
      @(negedge clk);
`ifdef MPY_ARBITER_FIXED_PRIO_EN
      exp = tbl[i].exp_fp;
`else
      exp = tbl[i].exp_rr;
`endif
      check($sformatf("tbl%0d_ready", i), 64'(bus.o_req_ready), 64'(exp));
      step();
    end
    set_req(4'b0000);
    repeat (LAT + 3) step();

    // Single request latency.
    bus.i_req_valid       = 4'b0001;
    bus.i_req_a[11:0]     = 12'd100;
    bus.i_req_b[11:0]     = 12'd200;
    step();
    bus.i_req_valid = 4'b0000;
    wait_result("lat", cyc);
    check("lat_cycles", 64'(cyc), 64'(LAT + 1));
    check("lat_idx",    64'(bus.o_res_idx), 64'd0);
    check("lat_p",      64'(bus.o_res_p),   64'd20000);
    repeat (3) step();

    // Maximum operands on the highest requester.
    bus.i_req_valid    = 4'b1000;
    bus.i_req_a[47:36] = 12'hFFF;
    bus.i_req_b[47:36] = 12'hFFF;
    step();
    bus.i_req_valid = 4'b0000;
    wait_result("max", cyc);
    check("max_idx", 64'(bus.o_res_idx), 64'd3);
    check("max_p",   64'(bus.o_res_p),   64'hFFE001);
    repeat (3) step();

`ifndef MPY_ARBITER_FIXED_PRIO_EN
    // All requesters valid after reset: grants and results in 0,1,2,3,0 order.
    pulse_reset();
    idxs.delete();
    first_c = -1;
    last_c  = -1;
    for (int c = 0; c < 12; c++) begin
      if (c < 5) set_req(4'b1111);
      else set_req(4'b0000);
      @(negedge clk);
      if (c < 5) check($sformatf("rr_grant%0d", c), 64'(bus.o_req_ready), 64'(1 << (c % 4)));
      if (bus.o_res_valid) begin
        idxs.push_back(int'(bus.o_res_idx));
        if (first_c < 0) first_c = c;
        last_c = c;
      end
      step();
    end
    check("rr_nres", 64'(idxs.size()), 64'd5);
    check("rr_b2b",  64'(last_c - first_c), 64'd4);
    for (int i = 0; i < idxs.size() && i < 5; i++)
      check($sformatf("rr_res%0d", i), 64'(idxs[i]), 64'(i % 4));
`else
    // Fixed priority: requester 1 starves requester 2 until it drops.
    for (int c = 0; c < 5; c++) begin
      set_req(4'b0110);
      @(negedge clk);
      check($sformatf("fp_hold%0d", c), 64'(bus.o_req_ready), 64'b0010);
      step();
    end
    set_req(4'b0100);
    @(negedge clk);
    check("fp_drop", 64'(bus.o_req_ready), 64'b0100);
    step();
    set_req(4'b0000);
    repeat (LAT + 3) step();
`endif

    // Result stall freezes the pipeline; nothing is lost after release.
    for (int c = 0; c < 6; c++) begin
      set_req(4'b1111);
      step();
    end
    bus.i_res_ready = 1'b0;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      if (c == 0) begin
        check("stall_valid", 64'(bus.o_res_valid), 64'd1);
        held = bus.o_res_p;
      end
      check("stall_ce",    64'(bus.o_mpy_ce),    64'd0);
      check("stall_ready", 64'(bus.o_req_ready), 64'd0);
      check("stall_p",     64'(bus.o_res_p),     64'(held));
      step();
      set_req(4'b1111);
    end
    bus.i_res_ready = 1'b1;
    set_req(4'b0000);
    repeat (LAT + 4) step();

    // Reset with results in flight: everything discarded, requester 0 next.
    for (int c = 0; c < 6; c++) begin
      set_req(4'b1111);
      step();
    end
    check("rstmid_pre", 64'(bus.o_res_valid), 64'd1);
    rst_n = 1'b0;
    set_req(4'b0000);
    #1;
    check("rstmid_valid", 64'(bus.o_res_valid), 64'd0);
    step();
    rst_n = 1'b1;
    for (int c = 0; c < LAT + 3; c++) begin
      @(negedge clk);
      check($sformatf("rstmid_quiet%0d", c), 64'(bus.o_res_valid), 64'd0);
      step();
    end
    set_req(4'b1111);
    @(negedge clk);
    check("rstmid_first", 64'(bus.o_req_ready), 64'b0001);
    step();
    set_req(4'b0000);
    repeat (LAT + 3) step();

    // Randomized traffic with random consumer back-pressure.
    n_res = 0;
    for (int c = 0; c < 400; c++) begin
      set_req(4'($urandom));
      bus.i_res_ready = ($urandom_range(0, 3) != 0);
      step();
      if (bus.o_res_valid) n_res++;
    end
    bus.i_res_ready = 1'b1;
    set_req(4'b0000);
    repeat (LAT + 6) step();
    @(negedge clk);
    check("end_idle", 64'(bus.o_res_valid), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
